// File: rtl/serial_pkg.sv
// Constants and receiver state type shared by the serial transmitter/receiver pair.
package serial_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    localparam int   FRAME_DATA_W = 8;
    localparam logic LINE_IDLE    = 1'b1;
    localparam logic START_BIT    = 1'b0;

endpackage

// File: rtl/s2p_receiver_hold_reg.sv
// One-entry holding register for received bytes with valid/ready handshake
// and overrun detection.
module rx_hold_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         perr_in,
    input  logic         ready,
    output logic [W-1:0] data_out,
    output logic         data_valid,
    output logic         parity_err,
    output logic         overrun
);

    logic [W-1:0] r_data;
    logic         r_valid;
    logic         r_perr;
    logic         r_overrun;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            // a load accepted in the same cycle as the old byte is not an overrun
            r_overrun <= load && r_valid && !ready;
            if (load) begin
                r_data  <= din;
                r_perr  <= perr_in;
                r_valid <= 1'b1;
            end else if (ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign parity_err = r_perr;
    assign overrun    = r_overrun;

endmodule

// File: rtl/s2p_receiver.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, parity, stop.
// Each rising edge samples one bit of the line.
module s2p_receiver
    import serial_pkg::*;
#(
    parameter int DATA_W     = FRAME_DATA_W,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              start,
    input  logic              sin,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    rx_state_t         r_state;
    rx_state_t         w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_perr;
    logic              r_frame_err;
    logic              w_load;
    logic              w_frame_bad;

    always_ff @(posedge clk) begin
        if (start) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_frame_bad = 1'b0;
        case (r_state)
            IDLE:   if (sin == START_BIT) w_next = DATA;
            DATA:   if (r_cnt == CNT_W'(DATA_W - 1)) w_next = PARITY;
            PARITY: w_next = STOP;
            STOP: begin
                w_next = IDLE;
                if (sin == LINE_IDLE) w_load      = 1'b1;
                else                  w_frame_bad = 1'b1;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (start) begin
            r_cnt       <= '0;
            r_shift     <= '0;
            r_perr      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_frame_bad;
            case (r_state)
                IDLE: r_cnt <= '0;
                DATA: begin
                    r_shift <= {sin, r_shift[DATA_W-1:1]};
                    r_cnt   <= r_cnt + 1'b1;
                end
                PARITY: r_perr <= ^r_shift ^ sin ^ PARITY_ODD;
                default: ;
            endcase
        end
    end

    rx_hold_reg #(.W(DATA_W)) u_hold (
        .clk        (clk),
        .rst        (start),
        .load       (w_load),
        .din        (r_shift),
        .perr_in    (r_perr),
        .ready      (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    assign frame_err = r_frame_err;
    assign busy      = (r_state != IDLE);

endmodule

// File: doc/s2p_receiver.md
# s2p_receiver

Serial-to-parallel frame receiver that consumes the single-bit line driven by the team's parallel-to-serial transmitter. The frame is: start bit (0), 8 data bits LSB first, one even-parity bit, then line high (stop/idle). The block samples one bit per clock on the rising edge, which centres each sample in the bit launched on the transmitter's falling edge. It checks parity and framing, then presents each byte through a one-entry holding register with a valid/ready handshake.

## Interface
- `DATA_W`, 8: data bits per frame.
- `PARITY_ODD`, 0: 0 = even parity (XOR of data bits), 1 = odd.

- `clk` in 1: single clock. All state updates on the rising edge.
- `start` in 1: reset. Synchronous, active-high.
- `sin` in 1: serial line. Idle high.
- `data_out` out DATA_W: received byte in the holding register.
- `data_valid` out 1: holding register full.
- `data_ready` in 1: consumer accepts `data_out` when high together with `data_valid`.
- `parity_err` out 1: parity flag stored with `data_out`. Valid while `data_valid` is high.
- `frame_err` out 1: one-cycle pulse when the stop sample is 0.
- `overrun` out 1: one-cycle pulse when a completed frame overwrites an unaccepted byte.
- `busy` out 1: high while in any state other than IDLE.

## Operation
- FSM states: IDLE, DATA, PARITY, STOP.
- IDLE:
  - `sin`=0 → DATA, with bit counter = 0.
  - `sin`=1 → stay in IDLE.
- DATA:
  - Each cycle, shift `sin` into the MSB of the shift register (right shift), so the first bit ends up in bit 0.
  - Increment the counter.
  - After the DATA_W-th sample → PARITY.
- PARITY:
  - Store `perr = ^shift ^ sin ^ PARITY_ODD`.
  - → STOP.
- STOP, `sin`=1 (good frame):
  - Load the holding register: `data_out`←shift, `parity_err`←perr, `data_valid`←1.
  - → IDLE.
- STOP, `sin`=0:
  - Discard the frame and pulse `frame_err`.
  - → IDLE.
  - The next IDLE sample decides whether a new frame starts.
- Handshake:
  - `data_valid && data_ready` clears `data_valid` on the next edge.
  - `data_out` and `parity_err` hold their values until overwritten.
- Frames with a parity error are still delivered, with `parity_err`=1.
- Overrun: good frame completes while `data_valid`=1 and `data_ready`=0.
  - The new byte overwrites the holding register.
  - `overrun` pulses.
- Simultaneous load and accept (`data_ready`=1 in the same cycle): the new byte loads, `data_valid` stays 1, and there is no overrun.
- Reset (`start`=1), including mid-frame:
  - State → IDLE; counter and shift register → 0.
  - `data_out`=0, `data_valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0, `busy`=0.
  - The partial frame is discarded.

## Timing
- Start bit sampled at edge T0. Data bits d0..d7 sampled at T1..T8, parity at T9, stop at T10.
- `data_valid` and `data_out` are visible after T10. Latency is 11 cycles from the start-sample edge.
- Back-to-back frames (one stop cycle between frames) are received with no gap. The next start sample is T11.
- `busy` rises after T0 and falls after T10.
- `frame_err` and `overrun` are registered pulses, high exactly one cycle after T10.

## Structure
- Shared package `serial_pkg`:
  - state enum `rx_state_t` {IDLE, DATA, PARITY, STOP};
  - `FRAME_DATA_W`=8;
  - `LINE_IDLE`=1'b1, `START_BIT`=1'b0.
- The transmitter uses the same constants.
- One natural sub-module: `rx_hold_reg`.
  - Holding register, valid/ready handshake and overrun detection.
  - Ports: load, din, perr_in, ready → data_out, data_valid, parity_err, overrun.
- FSM, counter and shift register stay in the top module.

## Test plan
1. Send 0xA5: bits 0,1,0,1,0,0,1,0,1,0,1 (start, data LSB first, parity 0, stop). Hold `data_ready`=0 → after T10, `data_out`=0xA5, `data_valid`=1, `parity_err`=0; `data_valid` holds until `data_ready`=1.
2. Send 0x01 with parity bit 0 (correct value is 1) → `data_out`=0x01, `parity_err`=1, `frame_err`=0.
3. Send 0x3C with the stop sample forced to 0 → `frame_err` pulses one cycle, `data_valid` stays 0; a following 0x55 frame is received correctly.
4. Send 0x3C then 0xC3 back-to-back with `data_ready`=0 → `overrun` pulses after the second frame, `data_out`=0xC3. Repeat with `data_ready`=1 at the second frame's T10 → no overrun.
5. Assert `start` at T5 of a frame, release it, then send 0x7E → all outputs are 0 during reset, the partial frame never appears, and 0x7E is received cleanly.
6. Loopback with the team's transmitter on the opposite clock edge, random bytes over 1000 frames → every byte matches, with zero parity, frame or overrun errors when `data_ready`=1.
